// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module : pic_pkg
// Purpose: Shared types and constants for the PIC16F54-class sequencer:
//          ALU8 operation codes, instruction phases, decode classes and the
//          opcode mask/match pairs for the 12-bit baseline instruction set.
// Ports  : (package, none)
// Rev    : 1.0 - initial release
// ============================================================================
package pic_pkg;

  localparam int         PIC_PC_W      = 9;
  localparam logic [8:0] PIC_RESET_VEC = 9'h1FF;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_IOR    = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_PASS_B = 4'd5,
    ALU_INC    = 4'd6,
    ALU_DEC    = 4'd7,
    ALU_BCLR   = 4'd8,
    ALU_BSET   = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_phase_e;

  // Which STATUS bits an instruction is allowed to update.
  typedef enum logic [1:0] {FL_NONE = 2'd0, FL_Z = 2'd1, FL_ALL = 2'd2} flag_cls_e;

  // Control-flow behaviour resolved at Q4.
  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_GOTO  = 3'd1,
    BR_CALL  = 3'd2,
    BR_RETLW = 3'd3,
    BR_SKZ   = 3'd4,   // skip when the ALU result is zero
    BR_BTFSC = 3'd5,
    BR_BTFSS = 3'd6
  } br_cls_e;

  // Opcode field masks (top 7 / 6 / 4 / 3 bits of the instruction word).
  localparam logic [11:0] M_7 = 12'hFE0;
  localparam logic [11:0] M_6 = 12'hFC0;
  localparam logic [11:0] M_4 = 12'hF00;
  localparam logic [11:0] M_3 = 12'hE00;

  localparam logic [11:0] V_MOVWF  = 12'h020;
  localparam logic [11:0] V_SUBWF  = 12'h080;
  localparam logic [11:0] V_DECF   = 12'h0C0;
  localparam logic [11:0] V_IORWF  = 12'h100;
  localparam logic [11:0] V_ANDWF  = 12'h140;
  localparam logic [11:0] V_XORWF  = 12'h180;
  localparam logic [11:0] V_ADDWF  = 12'h1C0;
  localparam logic [11:0] V_MOVF   = 12'h200;
  localparam logic [11:0] V_INCF   = 12'h280;
  localparam logic [11:0] V_DECFSZ = 12'h2C0;
  localparam logic [11:0] V_INCFSZ = 12'h3C0;
  localparam logic [11:0] V_BCF    = 12'h400;
  localparam logic [11:0] V_BSF    = 12'h500;
  localparam logic [11:0] V_BTFSC  = 12'h600;
  localparam logic [11:0] V_BTFSS  = 12'h700;
  localparam logic [11:0] V_RETLW  = 12'h800;
  localparam logic [11:0] V_CALL   = 12'h900;
  localparam logic [11:0] V_GOTO   = 12'hA00;
  localparam logic [11:0] V_MOVLW  = 12'hC00;
  localparam logic [11:0] V_IORLW  = 12'hD00;
  localparam logic [11:0] V_ANDLW  = 12'hE00;
  localparam logic [11:0] V_XORLW  = 12'hF00;

  function automatic logic op_match(input logic [11:0] ir,
                                    input logic [11:0] mask,
                                    input logic [11:0] val);
    return (ir & mask) == val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_seq_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : pic_decode
// Purpose: Combinational decoder for the 12-bit baseline instruction word.
//          Undefined encodings fall through to the NOP defaults.
// Ports  : ir       - instruction register
//          alu_op   - ALU8 operation
//          b_lit    - 1: ALU B = ir[7:0], 0: ALU B = file data
//          wr_f     - write result to the file register at Q4
//          wr_w     - write result to W at Q4
//          res_w    - result is W itself (MOVWF), ALU output unused
//          flag_cls - STATUS bits to update
//          br_cls   - branch/skip class
// Rev    : 1.0 - initial release
// ============================================================================
module pic_decode
  import pic_pkg::*;
(
  input  logic [11:0] ir,
  output alu_op_e     alu_op,
  output logic        b_lit,
  output logic        wr_f,
  output logic        wr_w,
  output logic        res_w,
  output flag_cls_e   flag_cls,
  output br_cls_e     br_cls
);

  // File-register op whose destination comes from the d bit (ir[5]).
  logic fop;

  always_comb begin
    alu_op   = ALU_PASS_B;
    b_lit    = 1'b0;
    wr_f     = 1'b0;
    wr_w     = 1'b0;
    res_w    = 1'b0;
    flag_cls = FL_NONE;
    br_cls   = BR_NONE;
    fop      = 1'b0;

    if (op_match(ir, M_7, V_MOVWF)) begin
      wr_f  = 1'b1;
      res_w = 1'b1;
    end
    else if (op_match(ir, M_6, V_SUBWF))  begin alu_op = ALU_SUB;    fop = 1'b1; flag_cls = FL_ALL; end
    else if (op_match(ir, M_6, V_DECF))   begin alu_op = ALU_DEC;    fop = 1'b1; flag_cls = FL_Z;   end
    else if (op_match(ir, M_6, V_IORWF))  begin alu_op = ALU_IOR;    fop = 1'b1; flag_cls = FL_Z;   end
    else if (op_match(ir, M_6, V_ANDWF))  begin alu_op = ALU_AND;    fop = 1'b1; flag_cls = FL_Z;   end
    else if (op_match(ir, M_6, V_XORWF))  begin alu_op = ALU_XOR;    fop = 1'b1; flag_cls = FL_Z;   end
    else if (op_match(ir, M_6, V_ADDWF))  begin alu_op = ALU_ADD;    fop = 1'b1; flag_cls = FL_ALL; end
    else if (op_match(ir, M_6, V_MOVF))   begin alu_op = ALU_PASS_B; fop = 1'b1; flag_cls = FL_Z;   end
    else if (op_match(ir, M_6, V_INCF))   begin alu_op = ALU_INC;    fop = 1'b1; flag_cls = FL_Z;   end
    else if (op_match(ir, M_6, V_DECFSZ)) begin alu_op = ALU_DEC;    fop = 1'b1; br_cls = BR_SKZ;   end
    else if (op_match(ir, M_6, V_INCFSZ)) begin alu_op = ALU_INC;    fop = 1'b1; br_cls = BR_SKZ;   end
    else if (op_match(ir, M_4, V_BCF))    begin alu_op = ALU_BCLR;   wr_f = 1'b1; end
    else if (op_match(ir, M_4, V_BSF))    begin alu_op = ALU_BSET;   wr_f = 1'b1; end
    else if (op_match(ir, M_4, V_BTFSC))  begin br_cls = BR_BTFSC; end
    else if (op_match(ir, M_4, V_BTFSS))  begin br_cls = BR_BTFSS; end
    else if (op_match(ir, M_4, V_RETLW))  begin b_lit = 1'b1; wr_w = 1'b1; br_cls = BR_RETLW; end
    else if (op_match(ir, M_4, V_CALL))   begin br_cls = BR_CALL; end
    else if (op_match(ir, M_3, V_GOTO))   begin br_cls = BR_GOTO; end
    else if (op_match(ir, M_4, V_MOVLW))  begin b_lit = 1'b1; wr_w = 1'b1; end
    else if (op_match(ir, M_4, V_IORLW))  begin alu_op = ALU_IOR; b_lit = 1'b1; wr_w = 1'b1; flag_cls = FL_Z; end
    else if (op_match(ir, M_4, V_ANDLW))  begin alu_op = ALU_AND; b_lit = 1'b1; wr_w = 1'b1; flag_cls = FL_Z; end
    else if (op_match(ir, M_4, V_XORLW))  begin alu_op = ALU_XOR; b_lit = 1'b1; wr_w = 1'b1; flag_cls = FL_Z; end

    if (fop) begin
      wr_f = ir[5];
      wr_w = ~ir[5];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pic_seq_ctrl
// Purpose: Instruction sequencer for the PIC16F54-class core. Runs the
//          Q1..Q4 instruction cycle, owns PC, W, STATUS {Z,DC,C}, the 2-deep
//          return stack and skip/branch flush, and drives ALU8 / Reg_File.
// Ports  : clk, rst_n (sync, active low), en (sampled at Q4->Q1)
//          prog_addr/prog_data      - program memory
//          rf_addr/rf_rdata/rf_wdata/rf_we - register file
//          alu_op/alu_a/alu_b/alu_bit, alu_y/alu_z/alu_c/alu_dc - ALU8
//          w_out, status_out {Z,DC,C}, q_phase (0=Q1 .. 3=Q4)
// Rev    : 1.0 - initial release
// ============================================================================
module pic_seq_ctrl
  import pic_pkg::*;
#(
  parameter int              PC_W      = PIC_PC_W,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(PIC_RESET_VEC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [PC_W-1:0] prog_addr,
  input  logic [11:0]     prog_data,
  output logic [4:0]      rf_addr,
  input  logic [7:0]      rf_rdata,
  output logic [7:0]      rf_wdata,
  output logic            rf_we,
  output logic [3:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_bit,
  input  logic [7:0]      alu_y,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic            alu_dc,
  output logic [7:0]      w_out,
  output logic [2:0]      status_out,
  output logic [1:0]      q_phase
);

  q_phase_e        phase, phase_nx;
  logic            held, held_nx;     // parked in Q4 because en was low
  logic [PC_W-1:0] pc, stack0, stack1;
  logic [11:0]     ir;
  logic [7:0]      w, res;
  logic [2:0]      status, flg;       // {Z,DC,C}
  logic            flush;             // next fetched word executes as NOP
  logic            hold_pc;           // branch target already in pc: no increment
  logic            wb;
  logic            skip_bit;

  alu_op_e   dec_op;
  logic      dec_b_lit, dec_wr_f, dec_wr_w, dec_res_w;
  flag_cls_e dec_flags;
  br_cls_e   dec_br;

  pic_decode u_decode (
    .ir       (ir),
    .alu_op   (dec_op),
    .b_lit    (dec_b_lit),
    .wr_f     (dec_wr_f),
    .wr_w     (dec_wr_w),
    .res_w    (dec_res_w),
    .flag_cls (dec_flags),
    .br_cls   (dec_br)
  );

  // Phase FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= Q1;
      held  <= 1'b0;
    end else begin
      phase <= phase_nx;
      held  <= held_nx;
    end
  end

  // Phase FSM next state and file write strobe. A held Q4 repeats with no
  // side effects until en returns high.
  always_comb begin
    phase_nx = phase;
    held_nx  = held;
    rf_we    = 1'b0;
    case (phase)
      Q1: phase_nx = Q2;
      Q2: phase_nx = Q3;
      Q3: phase_nx = Q4;
      Q4: begin
        rf_we    = dec_wr_f & ~held;
        phase_nx = en ? Q1 : Q4;
        held_nx  = ~en;
      end
      default: phase_nx = Q1;
    endcase
  end

  assign wb       = (phase == Q4) && !held;
  assign skip_bit = rf_rdata[ir[7:5]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_VEC;
      ir      <= 12'h000;
      w       <= 8'h00;
      status  <= 3'b000;
      stack0  <= '0;
      stack1  <= '0;
      flush   <= 1'b0;
      hold_pc <= 1'b0;
      res     <= 8'h00;
      flg     <= 3'b000;
    end else begin
      if (phase == Q1) begin
        ir      <= flush ? 12'h000 : prog_data;
        flush   <= 1'b0;
        hold_pc <= 1'b0;
        if (!hold_pc) pc <= pc + PC_W'(1);
      end
      if (phase == Q3) begin
        res <= dec_res_w ? w : alu_y;
        flg <= {alu_z, alu_dc, alu_c};
      end
      if (wb) begin
        if (dec_wr_w) w <= res;
        case (dec_flags)
          FL_Z:    status[2] <= flg[2];
          FL_ALL:  status    <= flg;
          default: ;
        endcase
        // Branches load pc now and flush the Q1 that follows; that Q1 must not
        // advance pc or the target word would be stepped over.
        case (dec_br)
          BR_GOTO: begin
            pc      <= PC_W'(ir[8:0]);
            flush   <= 1'b1;
            hold_pc <= 1'b1;
          end
          BR_CALL: begin
            stack1  <= stack0;
            stack0  <= pc;
            pc      <= PC_W'({1'b0, ir[7:0]});
            flush   <= 1'b1;
            hold_pc <= 1'b1;
          end
          BR_RETLW: begin
            pc      <= stack0;
            stack0  <= stack1;
            flush   <= 1'b1;
            hold_pc <= 1'b1;
          end
          BR_SKZ:   if (res == 8'h00) flush <= 1'b1;
          BR_BTFSC: if (!skip_bit)    flush <= 1'b1;
          BR_BTFSS: if (skip_bit)     flush <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign prog_addr  = pc;
  assign rf_addr    = ir[4:0];
  assign rf_wdata   = res;
  assign alu_op     = dec_op;
  assign alu_a      = w;
  assign alu_b      = dec_b_lit ? ir[7:0] : rf_rdata;
  assign alu_bit    = ir[7:5];
  assign w_out      = w;
  assign status_out = status;
  assign q_phase    = phase;

endmodule
`default_nettype wire

// File: tb/tb_pic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pic_seq_ctrl
// Purpose: Directed program for pic_seq_ctrl with a behavioural ALU8, register
//          file and program ROM. Expected per-instruction state (fetch address,
//          W, STATUS at each Q1) and expected file writes are queued up front;
//          a monitor pops and compares whenever the DUT presents them.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pic_seq_ctrl;
  import pic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [8:0]  prog_addr;
  logic [11:0] prog_data;
  logic [4:0]  rf_addr;
  logic [7:0]  rf_rdata, rf_wdata;
  logic        rf_we;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [2:0]  alu_bit;
  logic        alu_z, alu_c, alu_dc;
  logic [7:0]  w_out;
  logic [2:0]  status_out;
  logic [1:0]  q_phase;

  int checks = 0;
  int errors = 0;

  logic [11:0] pmem [512];
  logic [7:0]  rf   [32];
  logic        rf_init = 1'b1;

  logic [19:0] obs_q [$];   // {prog_addr, w, status} expected at each Q1
  logic [12:0] wr_q  [$];   // {rf_addr, rf_wdata} expected at each write

  always #5 clk = ~clk;

  pic_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_bit(alu_bit),
    .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c), .alu_dc(alu_dc),
    .w_out(w_out), .status_out(status_out), .q_phase(q_phase)
  );

  assign prog_data = pmem[prog_addr];
  assign rf_rdata  = rf[rf_addr];

  // ALU8 behaviour: SUB is f - W with C = no borrow, DC = no nibble borrow.
  always_comb begin
    alu_y  = 8'h00;
    alu_c  = 1'b0;
    alu_dc = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_dc = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'd15;
      end
      ALU_SUB: begin
        alu_y  = alu_b - alu_a;
        alu_c  = alu_b >= alu_a;
        alu_dc = alu_b[3:0] >= alu_a[3:0];
      end
      ALU_AND:    alu_y = alu_a & alu_b;
      ALU_IOR:    alu_y = alu_a | alu_b;
      ALU_XOR:    alu_y = alu_a ^ alu_b;
      ALU_PASS_B: alu_y = alu_b;
      ALU_INC:    alu_y = alu_b + 8'h01;
      ALU_DEC:    alu_y = alu_b - 8'h01;
      ALU_BCLR:   alu_y = alu_b & ~(8'h01 << alu_bit);
      ALU_BSET:   alu_y = alu_b | (8'h01 << alu_bit);
      default:    alu_y = 8'h00;
    endcase
    alu_z = (alu_y == 8'h00);
  end

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
      rf[16] <= 8'h20;
      rf[17] <= 8'h01;
      rf[19] <= 8'hFF;
    end else if (rf_we) begin
      rf[rf_addr] <= rf_wdata;
    end
  end

  function automatic logic [11:0] f_op(input logic [5:0] op, input logic d, input logic [4:0] f);
    return {op, d, f};
  endfunction
  function automatic logic [11:0] b_op(input logic [3:0] op, input logic [2:0] b, input logic [4:0] f);
    return {op, b, f};
  endfunction

  // Monitor: compares each Q1 state and each file write against the queues.
  initial begin
    logic [19:0] eo, go;
    logic [12:0] ew, gw;
    forever begin
      @(negedge clk);
      if (rst_n && q_phase == 2'd0) begin
        checks++;
        go = {prog_addr, w_out, status_out};
        if (obs_q.size() == 0) begin
          errors++;
          $display("FAIL q1_state: unexpected fetch got addr=%h w=%h st=%b, none required",
                   prog_addr, w_out, status_out);
        end else begin
          eo = obs_q.pop_front();
          if (go !== eo) begin
            errors++;
            $display("FAIL q1_state: got addr=%h w=%h st=%b, required addr=%h w=%h st=%b",
                     go[19:11], go[10:3], go[2:0], eo[19:11], eo[10:3], eo[2:0]);
          end
        end
      end
      if (rst_n && rf_we) begin
        checks++;
        gw = {rf_addr, rf_wdata};
        if (q_phase != 2'd3 || wr_q.size() == 0) begin
          errors++;
          $display("FAIL rf_write: unexpected write phase=%0d addr=%h data=%h, pending=%0d",
                   q_phase, rf_addr, rf_wdata, wr_q.size());
        end else begin
          ew = wr_q.pop_front();
          if (gw !== ew) begin
            errors++;
            $display("FAIL rf_write: got addr=%h data=%h, required addr=%h data=%h",
                     gw[12:8], gw[7:0], ew[12:8], ew[7:0]);
          end
        end
      end
    end
  end

  task automatic wait_q3(input logic [8:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_phase == 2'd2 && prog_addr == addr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  localparam int N_OBS = 28;
  logic [19:0] exp_obs [N_OBS];

  initial begin
    bit ok;
    for (int i = 0; i < 512; i++) pmem[i] = 12'h000;
    pmem[9'h1FF] = 12'hCF0;                       // MOVLW 0xF0
    pmem[9'h000] = f_op(6'b000111, 1'b0, 5'h10);  // ADDWF 0x10,W
    pmem[9'h001] = f_op(6'b001011, 1'b1, 5'h11);  // DECFSZ 0x11,F
    pmem[9'h002] = 12'hC77;                       // MOVLW 0x77 (skipped)
    pmem[9'h003] = 12'h032;                       // MOVWF 0x12
    pmem[9'h004] = 12'hF10;                       // XORLW 0x10
    pmem[9'h005] = 12'h940;                       // CALL 0x40
    pmem[9'h040] = 12'h950;                       // CALL 0x50
    pmem[9'h050] = 12'h960;                       // CALL 0x60
    pmem[9'h060] = 12'h855;                       // RETLW 0x55
    pmem[9'h051] = 12'h855;                       // RETLW 0x55
    pmem[9'h041] = 12'hBA0;                       // GOTO 0x1A0
    pmem[9'h1A0] = f_op(6'b001000, 1'b0, 5'h12);  // MOVF 0x12,W
    pmem[9'h1A1] = b_op(4'b0111, 3'd4, 5'h12);    // BTFSS 0x12,4
    pmem[9'h1A2] = 12'hC99;                       // MOVLW 0x99 (skipped)
    pmem[9'h1A3] = b_op(4'b0110, 3'd4, 5'h12);    // BTFSC 0x12,4
    pmem[9'h1A4] = f_op(6'b000010, 1'b1, 5'h10);  // SUBWF 0x10,F
    pmem[9'h1A5] = f_op(6'b001111, 1'b0, 5'h13);  // INCFSZ 0x13,W
    pmem[9'h1A6] = 12'hC11;                       // MOVLW 0x11 (skipped)
    pmem[9'h1A7] = b_op(4'b0100, 3'd7, 5'h13);    // BCF 0x13,7
    pmem[9'h1A8] = f_op(6'b000111, 1'b1, 5'h10);  // ADDWF 0x10,F (reset in Q3)

    exp_obs = '{
      {9'h1FF, 8'h00, 3'd0}, {9'h000, 8'hF0, 3'd0}, {9'h001, 8'h10, 3'd1},
      {9'h002, 8'h10, 3'd1}, {9'h003, 8'h10, 3'd1}, {9'h004, 8'h10, 3'd1},
      {9'h005, 8'h00, 3'd5}, {9'h040, 8'h00, 3'd5}, {9'h040, 8'h00, 3'd5},
      {9'h050, 8'h00, 3'd5}, {9'h050, 8'h00, 3'd5}, {9'h060, 8'h00, 3'd5},
      {9'h060, 8'h00, 3'd5}, {9'h051, 8'h55, 3'd5}, {9'h051, 8'h55, 3'd5},
      {9'h041, 8'h55, 3'd5}, {9'h041, 8'h55, 3'd5}, {9'h1A0, 8'h55, 3'd5},
      {9'h1A0, 8'h55, 3'd5}, {9'h1A1, 8'h10, 3'd1}, {9'h1A2, 8'h10, 3'd1},
      {9'h1A3, 8'h10, 3'd1}, {9'h1A4, 8'h10, 3'd1}, {9'h1A5, 8'h10, 3'd3},
      {9'h1A6, 8'h00, 3'd3}, {9'h1A7, 8'h00, 3'd3}, {9'h1A8, 8'h00, 3'd3},
      {9'h1FF, 8'h00, 3'd0}
    };
    for (int i = 0; i < N_OBS; i++) obs_q.push_back(exp_obs[i]);
    wr_q.push_back({5'h11, 8'h00});
    wr_q.push_back({5'h12, 8'h10});
    wr_q.push_back({5'h10, 8'h10});
    wr_q.push_back({5'h13, 8'h7F});

    // Power-on reset.
    repeat (3) @(posedge clk);
    rf_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({prog_addr, q_phase, w_out, status_out, rf_we} !== {9'h1FF, 2'd0, 8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got addr=%h q=%0d w=%h st=%b we=%b, required 1ff/0/00/000/0",
               prog_addr, q_phase, w_out, status_out, rf_we);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Drop en during BCF at 0x1A7: it completes, then Q4 is held.
    wait_q3(9'h1A8, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_bcf: Q3 with addr=1a8 not seen, required within 400 cycles");
    end
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({q_phase, rf_we, prog_addr} !== {2'd3, 1'b0, 9'h1A8}) begin
        errors++;
        $display("FAIL en_hold: got q=%0d we=%b addr=%h, required q=3 we=0 addr=1a8",
                 q_phase, rf_we, prog_addr);
      end
    end
    en = 1'b1;

    // Reset during Q3 of ADDWF 0x10,F: no write, state back to reset values.
    wait_q3(9'h1A9, ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_addwf: Q3 with addr=1a9 not seen, required within 400 cycles");
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({prog_addr, q_phase, w_out, status_out, rf_we} !== {9'h1FF, 2'd0, 8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midcycle_reset: got addr=%h q=%0d w=%h st=%b we=%b, required 1ff/0/00/000/0",
               prog_addr, q_phase, w_out, status_out, rf_we);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 40 && obs_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL q1_drain: %0d Q1 states still pending, required 0", obs_q.size());
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL wr_drain: %0d writes still pending, required 0", wr_q.size());
    end
    checks++;
    if (rf[16] !== 8'h10) begin
      errors++;
      $display("FAIL rf_10: got %h, required 10", rf[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_seq_ctrl.md
Name: pic_seq_ctrl

Overview:
- Instruction sequencer and decoder for the PIC16F54-class core.
- Fetches 12-bit baseline instructions, runs the 4-phase Q1–Q4 instruction cycle, and drives the ALU8 operand/opcode lines and Reg_File address/write lines.
- Owns PC, W, STATUS flags (Z/DC/C), the 2-deep hardware stack and skip/branch flush.
- Sits between program memory and the ALU8/Reg_File datapath inside the PIC16F54 top.

Parameters:
- PC_W, 9, program counter width (512 words).
- RESET_VEC, 9'h1FF, PC value after reset.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  run enable; sampled only at Q4→Q1 boundary.
- prog_addr  out  PC_W  program memory address (= pc).
- prog_data  in  12  instruction word, valid combinationally for prog_addr.
- rf_addr  out  5  register file address (= ir[4:0]).
- rf_rdata  in  8  register file read data (combinational).
- rf_wdata  out  8  register file write data (= captured ALU result).
- rf_we  out  1  register file write strobe, Q4 only.
- alu_op  out  4  ALU8 operation code (package enum).
- alu_a  out  8  ALU A operand (= W).
- alu_b  out  8  ALU B operand (file data or literal ir[7:0]).
- alu_bit  out  3  bit index for BCF/BSF (= ir[7:5]).
- alu_y  in  8  ALU result.
- alu_z, alu_c, alu_dc  in  1 each  ALU flag outputs.
- w_out  out  8  W register.
- status_out  out  3  {Z,DC,C}.
- q_phase  out  2  current phase, 0=Q1 … 3=Q4.

Behaviour:
- Reset (rst_n low at edge): pc=RESET_VEC, q_phase=Q1, ir=12'h000, w=0, status=0, stack0=stack1=0, flush=0, rf_we=0, result reg=0. Reset mid-cycle aborts the instruction; no write occurs.
- Phase FSM: Q1→Q2→Q3→Q4→Q1, one clock per phase. At Q4→Q1 with en=0: hold in Q4 with rf_we=0, no state change (re-evaluated each clock).
- Q1: ir <= flush ? 12'h000 : prog_data; flush <= 0; pc <= pc+1, wraps 1FF→000.
- Q2: operand select; alu_b = rf_rdata for file ops, ir[7:0] for literal ops.
- Q3: result_reg <= alu_y; flags latched.
- Q4: write-back. d=1 → rf_we=1; d=0 → w <= result. MOVWF always writes the file. Literal ops write W. STATUS updated per class. Branch/skip resolved.
- Decode, 12-bit baseline; all undefined encodings execute as NOP:
  - 000000000000 NOP.
  - 0000001fffff MOVWF.
  - 000010d SUBWF, 000011d DECF, 000100d IORWF, 000101d ANDWF, 000110d XORWF, 000111d ADDWF.
  - 001000d MOVF, 001010d INCF, 001011d DECFSZ, 001111d INCFSZ.
  - 0100 BCF, 0101 BSF, 0110 BTFSC, 0111 BTFSS (bbb=ir[7:5]).
  - 1000 RETLW k, 1001 CALL k, 101 GOTO k9, 1100 MOVLW, 1101 IORLW, 1110 ANDLW, 1111 XORLW.
- Flags:
  - ADDWF/SUBWF update Z, DC, C.
  - Logic ops, MOVF, INCF, DECF, MOVLW(no: unchanged), IORLW/ANDLW/XORLW update Z only.
  - DECFSZ/INCFSZ, BCF/BSF, MOVWF, branches leave flags unchanged.
- Skips:
  - DECFSZ/INCFSZ skip when alu_y==0.
  - BTFSC skips when rf_rdata[b]==0; BTFSS when ==1.
  - A skip sets flush, so the next fetched instruction runs as NOP.
- GOTO: pc <= ir[8:0]; flush=1.
- CALL: stack1 <= stack0; stack0 <= pc; pc <= {1'b0, ir[7:0]}; flush=1. Overflow silently discards old stack1.
- RETLW: w <= k; pc <= stack0; stack0 <= stack1; stack1 unchanged (underflow returns stale value); flush=1.
- Branches and taken skips cost 2 instruction cycles. A skip landing on a GOTO executes the GOTO as NOP.
- rf_we asserted only in Q4 and never while executing a flushed NOP.

Decomposition:
- Package pic_pkg: alu_op enum (ADD, SUB, AND, IOR, XOR, PASS_B, INC, DEC, BCLR, BSET), q_phase enum, opcode mask/match constants, RESET_VEC default.
- Sub-module pic_decode (combinational ir → alu_op, b_sel, dest, flag mask, branch/skip class); sequencer and state stay in pic_seq_ctrl.

Test Plan:
- Reset: after rst_n low, prog_addr=1FF, q_phase=0, w=0; first Q1 fetches 1FF, then pc wraps to 000.
- MOVLW 8'hF0; ADDWF f=0x10 (f=0x20), d=0 → w=0x10, C=1, Z=0, DC=0; rf_we never high.
- DECFSZ f=0x01, d=1 → rf_we at Q4 with rf_wdata=0x00; following instruction executes as NOP (no write, w unchanged).
- CALL 0x40 from pc=0x005 three deep, then RETLW 0x55 twice → pc=0x041 then the outer return address; w=0x55; oldest return lost.
- GOTO 0x1A0 → next executed instruction fetched at 0x1A0; the one at old pc+1 is flushed.
- en=0 during an instruction → instruction completes, FSM holds in Q4 with pc stable; en=1 resumes at Q1. rst_n low during Q3 of ADDWF → no W/flag/file update.
